// File: rtl/fft_out_serializer_pkg.sv
// Shared types for the FFT output path: complex sample, buffer/FSM state enums
// and a width-parameterised bit-reverse helper.
package fft_out_serializer_pkg;

    localparam int unsigned SAMPLE_W    = 64;
    localparam int unsigned BITREV_MAXW = 16;
    localparam int unsigned BITREV_IW   = $clog2(BITREV_MAXW);

    typedef struct packed {
        logic signed [31:0] r;
        logic signed [31:0] i;
    } complex_product_t;

    typedef enum logic [1:0] {
        BUF_EMPTY    = 2'd0,
        BUF_FULL     = 2'd1,
        BUF_DRAINING = 2'd2
    } buf_state_e;

    typedef enum logic {
        SER_IDLE   = 1'b0,
        SER_STREAM = 1'b1
    } ser_state_e;

    // Reverse the low w bits of x; bits at and above w come back as zero.
    function automatic logic [BITREV_MAXW-1:0] bitrev(
        input logic [BITREV_MAXW-1:0] x,
        input int unsigned            w
    );
        logic [BITREV_MAXW-1:0] y;
        y = '0;
        for (int unsigned b = 0; b < BITREV_MAXW; b++) begin
            if (b < w) begin
                y[BITREV_IW'(b)] = x[BITREV_IW'(w - 1 - b)];
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/fft_out_serializer_frame_buf.sv
// One N-bin frame store plus its stream-mode tag: whole-frame write, one indexed read.
module fft_frame_buf
    import fft_out_serializer_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [N*SAMPLE_W-1:0] wr_frame,
    input  logic                  wr_mode,
    input  logic [$clog2(N)-1:0]  rd_addr,
    output complex_product_t      rd_data_c,
    output logic                  mode
);

    complex_product_t [N-1:0] frame_q, frame_d;
    logic                     mode_q, mode_d;

    always_comb begin
        frame_d = frame_q;
        mode_d  = mode_q;
        if (we) begin
            frame_d = wr_frame;
            mode_d  = wr_mode;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            frame_q <= frame_d;
            mode_q  <= mode_d;
        end
    end

    assign rd_data_c = frame_q[rd_addr];
    assign mode      = mode_q;

endmodule

// File: rtl/fft_out_serializer.sv
// Ping-pong frame buffer between fft_N_rad2 and the demapper: captures whole
// FFT frames and streams their bins one per handshake, optionally bit-reversed.
module fft_out_serializer
    import fft_out_serializer_pkg::*;
#(
    parameter int unsigned N           = 32,
    parameter int unsigned BIT_REVERSE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_mode,
    input  logic [N*SAMPLE_W-1:0] in_frame,
    output logic                  out_valid,
    input  logic                  out_ready,
    output complex_product_t      out_data,
    output logic [$clog2(N)-1:0]  out_index,
    output logic                  out_last,
    output logic                  out_mode,
    output logic                  overflow,
    output logic [15:0]           drop_count
);

    localparam int unsigned AW       = $clog2(N);
    localparam logic [AW-1:0] LAST_CNT = AW'(N - 1);
    localparam bit          BR       = (BIT_REVERSE != 0);

    ser_state_e        state_q, state_d;
    buf_state_e        buf_st_q [2];
    buf_state_e        buf_st_d [2];
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    complex_product_t  out_data_q, out_data_d;
    logic [AW-1:0]     out_index_q, out_index_d;
    logic              out_last_q, out_last_d;
    logic              out_mode_q, out_mode_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_count_q, drop_count_d;

    logic [1:0]        buf_we_c;
    complex_product_t  buf_rd_c [2];
    logic              buf_mode [2];
    logic [AW-1:0]     nxt_cnt_c;
    logic [AW-1:0]     rd_addr_c;
    logic              nxt_buf_c;

    // Address of the sample to present after the next register update; the
    // counter wraps to 0 at N-1, where the read side moves to the other buffer.
    always_comb begin
        nxt_cnt_c = (state_q == SER_STREAM) ? cnt_q + AW'(1) : '0;
        nxt_buf_c = (state_q == SER_STREAM && cnt_q == LAST_CNT) ? ~rd_sel_q : rd_sel_q;
        rd_addr_c = BR ? AW'(bitrev(BITREV_MAXW'(nxt_cnt_c), AW)) : nxt_cnt_c;
    end

    for (genvar g = 0; g < 2; g++) begin : g_buf
        fft_frame_buf #(.N(N)) u_buf (
            .clk       (clk),
            .reset     (reset),
            .we        (buf_we_c[g]),
            .wr_frame  (in_frame),
            .wr_mode   (in_mode),
            .rd_addr   (rd_addr_c),
            .rd_data_c (buf_rd_c[g]),
            .mode      (buf_mode[g])
        );
    end

    always_comb begin
        state_d      = state_q;
        buf_st_d     = buf_st_q;
        wr_sel_d     = wr_sel_q;
        rd_sel_d     = rd_sel_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_index_d  = out_index_q;
        out_last_d   = out_last_q;
        out_mode_d   = out_mode_q;
        overflow_d   = 1'b0;
        drop_count_d = drop_count_q;
        buf_we_c     = '0;

        // Capture side: a buffer freed on this same edge is still DRAINING here.
        if (in_valid) begin
            if (buf_st_q[0] == BUF_EMPTY && buf_st_q[1] == BUF_EMPTY) begin
                buf_we_c[wr_sel_q] = 1'b1;
                buf_st_d[wr_sel_q] = BUF_FULL;
                wr_sel_d           = ~wr_sel_q;
            end else if (buf_st_q[0] == BUF_EMPTY) begin
                buf_we_c[0] = 1'b1;
                buf_st_d[0] = BUF_FULL;
                wr_sel_d    = 1'b1;
            end else if (buf_st_q[1] == BUF_EMPTY) begin
                buf_we_c[1] = 1'b1;
                buf_st_d[1] = BUF_FULL;
                wr_sel_d    = 1'b0;
            end else begin
                overflow_d = 1'b1;
                if (drop_count_q != 16'hFFFF) begin
                    drop_count_d = drop_count_q + 16'd1;
                end
            end
        end

        unique case (state_q)
            SER_IDLE: begin
                if (buf_st_q[rd_sel_q] == BUF_FULL) begin
                    buf_st_d[rd_sel_q] = BUF_DRAINING;
                    out_valid_d        = 1'b1;
                    out_data_d         = buf_rd_c[nxt_buf_c];
                    out_index_d        = rd_addr_c;
                    out_last_d         = 1'b0;
                    out_mode_d         = buf_mode[nxt_buf_c];
                    state_d            = SER_STREAM;
                end
            end
            SER_STREAM: begin
                if (out_valid_q && out_ready) begin
                    cnt_d = nxt_cnt_c;
                    if (cnt_q == LAST_CNT) begin
                        buf_st_d[rd_sel_q] = BUF_EMPTY;
                        rd_sel_d           = ~rd_sel_q;
                        if (buf_st_q[nxt_buf_c] == BUF_FULL) begin
                            buf_st_d[nxt_buf_c] = BUF_DRAINING;
                            out_data_d          = buf_rd_c[nxt_buf_c];
                            out_index_d         = rd_addr_c;
                            out_last_d          = 1'b0;
                            out_mode_d          = buf_mode[nxt_buf_c];
                        end else begin
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            state_d     = SER_IDLE;
                        end
                    end else begin
                        out_data_d  = buf_rd_c[nxt_buf_c];
                        out_index_d = rd_addr_c;
                        out_last_d  = (nxt_cnt_c == LAST_CNT);
                        out_mode_d  = buf_mode[nxt_buf_c];
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SER_IDLE;
            buf_st_q[0]  <= BUF_EMPTY;
            buf_st_q[1]  <= BUF_EMPTY;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
            out_mode_q   <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            buf_st_q     <= buf_st_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
            out_mode_q   <= out_mode_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_index  = out_index_q;
    assign out_last   = out_last_q;
    assign out_mode   = out_mode_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer (N = 8): natural and bit-reversed
// instances share stimulus; a scoreboard queue holds the expected sample stream.
module tb_fft_out_serializer;
    import fft_out_serializer_pkg::*;

    localparam int unsigned N  = 8;
    localparam int unsigned AW = 3;

    typedef struct packed {
        logic [63:0]   data;
        logic [AW-1:0] idx;
        logic          last;
        logic          mode;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_mode;
    logic [N*64-1:0]   in_frame;
    logic              out_ready;

    logic              out_valid,  out_valid_b;
    logic [63:0]       out_data,   out_data_b;
    logic [AW-1:0]     out_index,  out_index_b;
    logic              out_last,   out_last_b;
    logic              out_mode,   out_mode_b;
    logic              overflow,   overflow_b;
    logic [15:0]       drop_count, drop_count_b;

    int                n_asserts = 0;
    int                n_fail    = 0;
    exp_t              q_nat[$];
    exp_t              q_br[$];
    bit                chk_br    = 1'b0;
    bit                stall_prev = 1'b0;
    exp_t              snap;

    always #5 clk = ~clk;

    fft_out_serializer #(.N(N), .BIT_REVERSE(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_mode(in_mode),
        .in_frame(in_frame), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .out_mode(out_mode), .overflow(overflow), .drop_count(drop_count)
    );

    fft_out_serializer #(.N(N), .BIT_REVERSE(1)) dut_br (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_mode(in_mode),
        .in_frame(in_frame), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_index(out_index_b), .out_last(out_last_b),
        .out_mode(out_mode_b), .overflow(overflow_b), .drop_count(drop_count_b)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached (asserts=%0d)", n_asserts);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] bin_val(input int fid, input int k);
        logic [31:0] r;
        logic [31:0] im;
        r  = 32'(fid * 256 + k);
        im = 32'(0) - r;
        return {r, im};
    endfunction

    function automatic logic [N*64-1:0] make_frame(input int fid);
        logic [N*64-1:0] f;
        for (int k = 0; k < N; k++) f[k*64 +: 64] = bin_val(fid, k);
        return f;
    endfunction

    function automatic logic [AW-1:0] rev3(input logic [AW-1:0] x);
        return {x[0], x[1], x[2]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int fid, input logic mode);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.data = bin_val(fid, k);
            e.idx  = AW'(k);
            e.last = (k == N - 1);
            e.mode = mode;
            q_nat.push_back(e);
            if (chk_br) begin
                e.idx  = rev3(AW'(k));
                e.data = bin_val(fid, int'(e.idx));
                q_br.push_back(e);
            end
        end
    endtask

    // Called with next-edge inputs already applied: a handshake happens at the coming edge.
    task automatic check_out();
        exp_t e;
        if (stall_prev) begin
            chk("hold_valid", 64'(out_valid), 64'(1'b1));
            chk("hold_data",  out_data, snap.data);
            chk("hold_index", 64'(out_index), 64'(snap.idx));
            chk("hold_last",  64'(out_last), 64'(snap.last));
            chk("hold_mode",  64'(out_mode), 64'(snap.mode));
        end
        if (out_valid && out_ready) begin
            chk("have_expect", 64'(q_nat.size() != 0), 64'(1'b1));
            if (q_nat.size() != 0) begin
                e = q_nat.pop_front();
                chk("data",  out_data, e.data);
                chk("index", 64'(out_index), 64'(e.idx));
                chk("last",  64'(out_last), 64'(e.last));
                chk("mode",  64'(out_mode), 64'(e.mode));
            end
        end
        if (chk_br && out_valid_b && out_ready) begin
            chk("br_have_expect", 64'(q_br.size() != 0), 64'(1'b1));
            if (q_br.size() != 0) begin
                e = q_br.pop_front();
                chk("br_data",  out_data_b, e.data);
                chk("br_index", 64'(out_index_b), 64'(e.idx));
                chk("br_last",  64'(out_last_b), 64'(e.last));
            end
        end
        stall_prev = out_valid && !out_ready;
        snap.data  = out_data;
        snap.idx   = out_index;
        snap.last  = out_last;
        snap.mode  = out_mode;
    endtask

    task automatic cyc(input bit iv, input int fid, input bit im, input bit rdy, input bit keep);
        in_valid  = iv;
        in_mode   = im;
        out_ready = rdy;
        if (iv) in_frame = make_frame(fid);
        if (iv && keep) push_frame(fid, im);
        check_out();
        @(negedge clk);
    endtask

    task automatic drain(input int max_cyc, input bit rnd);
        int c;
        c = 0;
        while (q_nat.size() != 0 && c < max_cyc) begin
            cyc(1'b0, 0, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
            c++;
        end
        chk("drain_done", 64'(q_nat.size()), 64'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_data"},  out_data, 64'(0));
        chk({tag, "_index"}, 64'(out_index), 64'(0));
        chk({tag, "_last"},  64'(out_last), 64'(0));
        chk({tag, "_mode"},  64'(out_mode), 64'(0));
        chk({tag, "_ovf"},   64'(overflow), 64'(0));
        chk({tag, "_drops"}, 64'(drop_count), 64'(0));
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_frame  = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b1;
        @(negedge clk);

        // Natural and bit-reversed order, one frame, consumer always ready.
        chk_br = 1'b1;
        cyc(1'b1, 0, 1'b0, 1'b1, 1'b1);
        chk("lat_early", 64'(out_valid), 64'(0));
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("lat_valid", 64'(out_valid), 64'(1));
        chk("lat_valid_br", 64'(out_valid_b), 64'(1));
        for (int c = 0; c < N; c++) cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("nat_consumed", 64'(q_nat.size()), 64'(0));
        chk("br_consumed", 64'(q_br.size()), 64'(0));
        chk("nat_idle", 64'(out_valid), 64'(0));
        chk_br = 1'b0;

        // Back-to-back frames, no bubble between them.
        cyc(1'b1, 1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 2, 1'b1, 1'b1, 1'b1);
        for (int c = 4; c < 2 + 2 * N; c++) cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("b2b_consumed", 64'(q_nat.size()), 64'(0));
        chk("b2b_idle", 64'(out_valid), 64'(0));

        // Overflow: third frame dropped while consumer stalls.
        cyc(1'b1, 3, 1'b0, 1'b0, 1'b1);
        chk("ovf_f1", 64'(overflow), 64'(0));
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4, 1'b1, 1'b0, 1'b1);
        chk("ovf_f2", 64'(overflow), 64'(0));
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5, 1'b0, 1'b0, 1'b0);
        chk("ovf_pulse", 64'(overflow), 64'(1));
        chk("ovf_count", 64'(drop_count), 64'(1));
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("ovf_single", 64'(overflow), 64'(0));
        chk("ovf_count_hold", 64'(drop_count), 64'(1));
        drain(40, 1'b0);
        chk("ovf_idle", 64'(out_valid), 64'(0));

        // Random backpressure with a second frame arriving mid-stream.
        cyc(1'b1, 6, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
        for (int c = 0; c < 5; c++) cyc(1'b0, 0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        cyc(1'b1, 7, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        drain(300, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle", 64'(out_valid), 64'(0));
        stall_prev = 1'b0;

        // Mid-frame reset after three samples.
        cyc(1'b1, 8, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_q", 64'(q_nat.size()), 64'(N - 3));
        reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        q_nat.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_idle0", 64'(out_valid), 64'(0));
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_idle1", 64'(out_valid), 64'(0));
        cyc(1'b1, 9, 1'b1, 1'b1, 1'b1);
        drain(30, 1'b0);
        chk("post_rst_end", 64'(out_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
